// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared encodings for the ID/EX operand-delivery stage.
//   - ALU a/b operand source selects (formerly pipe_defines.vh)
//   - REG_ZERO, the hard-wired zero register number
//   - ALU_ADD, the ALU function loaded into an empty stage (from alu_defines.vh)
package id_ex_stage_pkg;

    typedef enum logic {
        OPA_RS = 1'b0,
        OPA_RT = 1'b1
    } opa_sel_e;

    typedef enum logic [1:0] {
        OPB_RT    = 2'd0,
        OPB_IMM   = 2'd1,
        OPB_SHAMT = 2'd2,
        OPB_RS    = 2'd3
    } opb_sel_e;

    localparam int unsigned REG_ZERO = 0;

    localparam logic [3:0] ALU_ADD = 4'b0000;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: forwarding selector for one source register.
// Ports:
//   addr_i, data_i        registered source register number and read data
//   exm_reg_write_i/rd_i/result_i   EX/MEM writeback candidate
//   mwb_reg_write_i/rd_i/result_i   MEM/WB writeback candidate
//   fwd_data_o            EX/MEM result, else MEM/WB result, else data_i
// Register 0 is never forwarded.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              exm_reg_write_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic [DATA_W-1:0] exm_result_i,
    input  logic              mwb_reg_write_i,
    input  logic [REG_AW-1:0] mwb_rd_i,
    input  logic [DATA_W-1:0] mwb_result_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic addr_nz;

    assign addr_nz = (addr_i != REG_AW'(REG_ZERO));

    always_comb begin
        fwd_data_o = data_i;
        // Older stage first so the younger EX/MEM result overrides it.
        if (addr_nz && mwb_reg_write_i && (mwb_rd_i == addr_i)) begin
            fwd_data_o = mwb_result_i;
        end
        if (addr_nz && exm_reg_write_i && (exm_rd_i == addr_i)) begin
            fwd_data_o = exm_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// Captures decoded fields from ID, forwards EX/MEM and MEM/WB results onto
// the registered rs/rt values, selects ALU operands, and back-pressures ID
// on load-use hazards.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   id_*                         decoded instruction from ID
//   exm_*, mwb_*                 writeback info from EX/MEM and MEM/WB
//   stall_in, flush              downstream hold / kill
//   id_stall                     ID must hold its instruction
//   alu_a, alu_b, alu_func       ALU drive
//   ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
// Configuration macro: ID_EX_FWD_EN
//   defined   - EX/MEM and MEM/WB forwarding, only load-use bubbles
//   undefined - no forwarding; any RAW on EX or EX/MEM forces a bubble
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm32,
    input  logic [4:0]        id_shamt,
    input  logic              id_a_sel,
    input  logic [1:0]        id_b_sel,
    input  logic [3:0]        id_alu_func,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic [DATA_W-1:0] mwb_result,
    input  logic              stall_in,
    input  logic              flush,
    output logic              id_stall,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_func,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [DATA_W-1:0] ex_store_data
);

    // Stage registers
    logic              valid_q;
    logic [REG_AW-1:0] rs_addr_q, rt_addr_q, rd_q;
    logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
    logic [4:0]        shamt_q;
    opa_sel_e          a_sel_q;
    opb_sel_e          b_sel_q;
    logic [3:0]        func_q;
    logic              reg_write_q, mem_read_q, mem_write_q;

    logic              uses_rs, uses_rt;
    logic              ex_nz;
    logic              load_use;
    logic              hazard;
    logic [DATA_W-1:0] rs_fwd, rt_fwd;
    logic              exm_fwd_en, mwb_fwd_en;

    // ---------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------
    assign uses_rs = (opa_sel_e'(id_a_sel) == OPA_RS) || (opb_sel_e'(id_b_sel) == OPB_RS);
    assign uses_rt = (opa_sel_e'(id_a_sel) == OPA_RT) || (opb_sel_e'(id_b_sel) == OPB_RT)
                   || id_mem_write;

    assign ex_nz = (rd_q != REG_AW'(REG_ZERO));

    assign load_use = valid_q && mem_read_q && ex_nz && id_valid
                    && ((uses_rs && (id_rs_addr == rd_q)) || (uses_rt && (id_rt_addr == rd_q)));

`ifdef ID_EX_FWD_EN
    assign hazard     = load_use;
    assign exm_fwd_en = exm_reg_write;
    assign mwb_fwd_en = mwb_reg_write;
`else
    logic ex_raw, exm_raw;

    // Without bypass paths every pending write in EX or EX/MEM must drain.
    assign ex_raw  = valid_q && reg_write_q && ex_nz
                   && ((uses_rs && (id_rs_addr == rd_q)) || (uses_rt && (id_rt_addr == rd_q)));
    assign exm_raw = exm_reg_write && (exm_rd != REG_AW'(REG_ZERO))
                   && ((uses_rs && (id_rs_addr == exm_rd)) || (uses_rt && (id_rt_addr == exm_rd)));
    assign hazard     = load_use || (id_valid && (ex_raw || exm_raw));
    // Gating the write enables leaves the muxes passing registered data.
    assign exm_fwd_en = 1'b0;
    assign mwb_fwd_en = 1'b0;
`endif

    assign id_stall = stall_in || hazard;

    // ---------------------------------------------------------------
    // Stage register: reset > flush > stall_in > bubble > load
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            a_sel_q     <= OPA_RS;
            b_sel_q     <= OPB_RT;
            func_q      <= ALU_ADD;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (flush || (!stall_in && hazard)) begin
            valid_q     <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_q        <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            a_sel_q     <= OPA_RS;
            b_sel_q     <= OPB_RT;
            func_q      <= ALU_ADD;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!stall_in) begin
            valid_q     <= id_valid;
            rs_addr_q   <= id_rs_addr;
            rt_addr_q   <= id_rt_addr;
            rd_q        <= id_rd_addr;
            rs_data_q   <= id_rs_data;
            rt_data_q   <= id_rt_data;
            imm_q       <= id_imm32;
            shamt_q     <= id_shamt;
            a_sel_q     <= opa_sel_e'(id_a_sel);
            b_sel_q     <= opb_sel_e'(id_b_sel);
            func_q      <= id_alu_func;
            reg_write_q <= id_valid && id_reg_write;
            mem_read_q  <= id_valid && id_mem_read;
            mem_write_q <= id_valid && id_mem_write;
        end
    end

    // ---------------------------------------------------------------
    // Forwarding and operand select
    // ---------------------------------------------------------------
    fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .addr_i          (rs_addr_q),
        .data_i          (rs_data_q),
        .exm_reg_write_i (exm_fwd_en),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_fwd_en),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .fwd_data_o      (rs_fwd)
    );

    fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .addr_i          (rt_addr_q),
        .data_i          (rt_data_q),
        .exm_reg_write_i (exm_fwd_en),
        .exm_rd_i        (exm_rd),
        .exm_result_i    (exm_result),
        .mwb_reg_write_i (mwb_fwd_en),
        .mwb_rd_i        (mwb_rd),
        .mwb_result_i    (mwb_result),
        .fwd_data_o      (rt_fwd)
    );

    always_comb begin
        alu_a = (a_sel_q == OPA_RT) ? rt_fwd : rs_fwd;
        alu_b = rt_fwd;
        case (b_sel_q)
            OPB_RT:    alu_b = rt_fwd;
            OPB_IMM:   alu_b = imm_q;
            OPB_SHAMT: alu_b = DATA_W'(shamt_q);
            OPB_RS:    alu_b = rs_fwd;
            default:   alu_b = rt_fwd;
        endcase
    end

    assign alu_func      = func_q;
    assign ex_valid      = valid_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// Expected values follow the ID_EX_FWD_EN setting of the build.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [3:0] ALU_ADD_EXP = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm32;
    logic [4:0]  id_shamt;
    logic        id_a_sel;
    logic [1:0]  id_b_sel;
    logic [3:0]  id_alu_func;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
    logic        stall_in, flush;
    logic        id_stall;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_func;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_store_data;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W (32),
        .REG_AW (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_rd_addr    (id_rd_addr),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm32      (id_imm32),
        .id_shamt      (id_shamt),
        .id_a_sel      (id_a_sel),
        .id_b_sel      (id_b_sel),
        .id_alu_func   (id_alu_func),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .exm_reg_write (exm_reg_write),
        .exm_rd        (exm_rd),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_rd        (mwb_rd),
        .mwb_result    (mwb_result),
        .stall_in      (stall_in),
        .flush         (flush),
        .id_stall      (id_stall),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_func      (alu_func),
        .ex_valid      (ex_valid),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_store_data (ex_store_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] sh, input logic asel,
                          input logic [1:0] bsel, input logic [3:0] fn, input logic rw,
                          input logic mr, input logic mw);
        id_valid     = v;
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        id_rd_addr   = rd;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_imm32     = imm;
        id_shamt     = sh;
        id_a_sel     = asel;
        id_b_sel     = bsel;
        id_alu_func  = fn;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
    endtask

    initial begin
        rst_n         = 1'b0;
        stall_in      = 1'b0;
        flush         = 1'b0;
        exm_reg_write = 1'b0;
        exm_rd        = '0;
        exm_result    = '0;
        mwb_reg_write = 1'b0;
        mwb_rd        = '0;
        mwb_result    = '0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        #1;
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_func", 32'(alu_func), 32'(ALU_ADD_EXP));
        check("rst_rw", 32'(ex_reg_write), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Forward priority on rs
        set_id(1, 5, 6, 7, 32'h100, 32'h200, 0, 0, 0, 0, 4'h3, 1, 0, 0);
        step();
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd = 5; mwb_result = 32'h22;
        #1;
        check("fwd_valid", 32'(ex_valid), 32'd1);
        check("fwd_func", 32'(alu_func), 32'h3);
        check("fwd_rd", 32'(ex_rd), 32'd7);
        check("fwd_exm", alu_a, FWD ? 32'h11 : 32'h100);
        check("fwd_b_rt", alu_b, 32'h200);
        check("raw_stall", 32'(id_stall), FWD ? 32'd0 : 32'd1);
        exm_reg_write = 0;
        #1;
        check("fwd_mwb", alu_a, FWD ? 32'h22 : 32'h100);

        // Register 0 never forwards
        mwb_reg_write = 0;
        set_id(1, 0, 6, 7, 32'h100, 32'h200, 0, 0, 0, 0, 4'h3, 1, 0, 0);
        step();
        exm_reg_write = 1; exm_rd = 0; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd = 0; mwb_result = 32'h22;
        #1;
        check("fwd_r0", alu_a, 32'h100);
        exm_reg_write = 0; mwb_reg_write = 0;

        // Shift operands
        set_id(1, 1, 2, 9, 32'hDEAD, 32'h1, 0, 31, 1, 2, 4'h8, 1, 0, 0);
        step();
        check("shift_a", alu_a, 32'h1);
        check("shift_b", alu_b, 32'h1F);

        // Load-use: lw $8, 4($29) then add $9, $8, $10
        set_id(1, 29, 8, 8, 32'h1000, 0, 32'h4, 0, 0, 1, ALU_ADD_EXP, 1, 1, 0);
        step();
        check("lw_mr", 32'(ex_mem_read), 32'd1);
        check("lw_a", alu_a, 32'h1000);
        check("lw_b", alu_b, 32'h4);
        set_id(1, 8, 10, 9, 32'h5555, 32'h7, 0, 0, 0, 0, ALU_ADD_EXP, 1, 0, 0);
        #1;
        check("lu_stall", 32'(id_stall), 32'd1);
        step();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_bub_rw", 32'(ex_reg_write), 32'd0);
        check("lu_bub_func", 32'(alu_func), 32'(ALU_ADD_EXP));
        check("lu_release", 32'(id_stall), 32'd0);
        step();
        mwb_reg_write = 1; mwb_rd = 8; mwb_result = 32'hABCD;
        #1;
        check("lu_loaded", 32'(ex_valid), 32'd1);
        check("lu_fwd_a", alu_a, FWD ? 32'hABCD : 32'h5555);
        check("lu_b", alu_b, 32'h7);
        mwb_reg_write = 0;

        // Downstream stall holds the stage
        stall_in = 1;
        set_id(1, 3, 4, 12, 32'h33, 32'h44, 0, 0, 0, 0, 4'h5, 1, 0, 0);
        #1;
        check("stall_ids", 32'(id_stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_rd", 32'(ex_rd), 32'd9);
            check("stall_a", alu_a, 32'h5555);
            check("stall_valid", 32'(ex_valid), 32'd1);
            check("stall_ids_c", 32'(id_stall), 32'd1);
        end

        // Flush beats stall
        flush = 1;
        step();
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_rd", 32'(ex_rd), 32'd0);
        check("flush_func", 32'(alu_func), 32'(ALU_ADD_EXP));
        check("flush_rw", 32'(ex_reg_write), 32'd0);
        stall_in = 0;
        #1;
        check("flush_no_ids", 32'(id_stall), 32'd0);
        flush = 0;

        // Invalid ID slot loads zero control
        set_id(0, 1, 2, 3, 32'h1, 32'h2, 0, 0, 0, 0, 4'h2, 1, 1, 1);
        step();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_rw", 32'(ex_reg_write), 32'd0);
        check("inv_mr", 32'(ex_mem_read), 32'd0);
        check("inv_mw", 32'(ex_mem_write), 32'd0);

        // Store data forwarding: sw $3, 8($2)
        set_id(1, 2, 3, 0, 32'h10, 32'h99, 32'h8, 0, 0, 1, ALU_ADD_EXP, 0, 0, 1);
        step();
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'h77;
        #1;
        check("st_mw", 32'(ex_mem_write), 32'd1);
        check("st_data", ex_store_data, FWD ? 32'h77 : 32'h99);
        exm_reg_write = 0;

        // addi $3 in EX, add with rs=$3 in ID
        set_id(1, 1, 0, 3, 32'h1, 0, 32'h5, 0, 0, 1, ALU_ADD_EXP, 1, 0, 0);
        step();
        set_id(1, 3, 4, 5, 32'h3, 32'h4, 0, 0, 0, 0, ALU_ADD_EXP, 1, 0, 0);
        #1;
        check("raw_ex_stall", 32'(id_stall), FWD ? 32'd0 : 32'd1);
        step();
        check("raw_ex_next", 32'(ex_valid), FWD ? 32'd1 : 32'd0);

        // Asynchronous reset with the stage full
        set_id(1, 20, 21, 22, 32'h1, 32'h2, 32'h3, 0, 0, 1, 4'h6, 1, 1, 0);
        step();
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        rst_n = 0;
        #1;
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_mr", 32'(ex_mem_read), 32'd0);
        check("arst_rw", 32'(ex_reg_write), 32'd0);
        check("arst_rd", 32'(ex_rd), 32'd0);
        check("arst_func", 32'(alu_func), 32'(ALU_ADD_EXP));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage sitting directly upstream of the ALU in the MIPS32 core.
- Captures decoded instruction fields from ID, applies EX/MEM and MEM/WB forwarding, selects the ALU operands and drives a/b/func into the ALU.
- Detects load-use hazards and back-pressures ID.
- Honours downstream stall and branch flush.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW each  source and destination register numbers
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data
- id_imm32  in  DATA_W  extended immediate
- id_shamt  in  5  shift amount field
- id_a_sel  in  1  ALU a source: 0=rs, 1=rt
- id_b_sel  in  2  ALU b source: 0=rt, 1=imm32, 2=shamt zero-extended, 3=rs
- id_alu_func  in  4  ALU function, encoded per alu_defines.vh
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control bits
- exm_reg_write  in  1  EX/MEM writes a register
- exm_rd  in  REG_AW  EX/MEM destination register
- exm_result  in  DATA_W  EX/MEM result
- mwb_reg_write  in  1  MEM/WB writes a register
- mwb_rd  in  REG_AW  MEM/WB destination register
- mwb_result  in  DATA_W  MEM/WB result
- stall_in  in  1  downstream busy; hold the stage
- flush  in  1  kill the instruction held in the stage
- id_stall  out  1  ID must hold its instruction this cycle
- alu_a, alu_b  out  DATA_W each  ALU operands
- alu_func  out  4  ALU function
- ex_valid  out  1  stage holds a valid instruction
- ex_rd  out  REG_AW  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered control bits
- ex_store_data  out  DATA_W  forwarded rt value, used by stores

Behaviour:
- Register update priority each edge: reset > flush > stall_in > load-use bubble > load.
- Reset (async, rst_n=0) or flush:
  - ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0
  - ex_rd = 0, all data fields = 0
  - alu_func = `ALU_ADD
- Bubble has the same contents as reset. Flush wins over stall_in.
- stall_in=1 and no flush: all stage registers hold.
- Load-use hazard (combinational):
  - Condition: ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ID uses rs or rt with an address equal to ex_rd.
  - ID uses rs when a_sel=0 or b_sel=3. ID uses rt when a_sel=1, b_sel=0, or id_mem_write=1.
  - On hazard (no stall_in, no flush): load a bubble at the next edge.
- Normal load: capture all id_* fields. ex_valid takes id_valid. When id_valid=0, the control bits are loaded as 0.
- id_stall = stall_in | load_use. Combinational, no extra latency. Flush does not assert id_stall.
- Forwarding (combinational, applied to the registered rs/rt addresses and data):
  - Priority EX/MEM > MEM/WB > registered data.
  - Never forward for register 0.
  - Forward only when the source stage has reg_write=1.
- Operand select after forwarding:
  - alu_a = a_sel ? rt_fwd : rs_fwd
  - alu_b by b_sel: rt_fwd, imm32, {27'd0, shamt}, rs_fwd
  - ex_store_data = rt_fwd
- Latency: one cycle from ID capture to driving the ALU. alu_a/alu_b may change combinationally with the exm_*/mwb_* inputs in the same cycle.
- While ex_valid=0, the ALU outputs are don't-care. Control outputs must still be 0.

Optional Feature:
- Macro: ID_EX_FWD_EN
- Defined: forwarding as specified above.
- Undefined:
  - No forwarding paths; rs_fwd/rt_fwd are the registered register-file data.
  - The hazard condition widens to any RAW between ID sources and a nonzero, reg_write, valid destination in EX (ex_rd) or EX/MEM (exm_rd). Such a hazard forces a bubble exactly like load-use.
  - Port list is unchanged; exm_result and mwb_* are unused.

Decomposition:
- Shared header pipe_defines.vh holds:
  - the a_sel/b_sel encodings (OPA_RS, OPA_RT, OPB_RT, OPB_IMM, OPB_SHAMT, OPB_RS)
  - the REG_ZERO constant
- The existing alu_defines.vh supplies the func encodings.
- Sub-module fwd_mux: one source-register forward selector (addr, data, exm_*, mwb_*) -> fwd_data. Instantiated twice, for rs and rt.

Test Plan:
- Reset mid-run: assert rst_n=0 with the stage full -> all control outputs 0 and alu_func=`ALU_ADD immediately, with no clock edge required.
- Forward priority: rs=5; exm_rd=5 with result 0x11; mwb_rd=5 with result 0x22; a_sel=0 -> alu_a=0x11. Drop exm_reg_write -> 0x22. Repeat with rs=0 -> registered data, no forwarding.
- Load-use: EX holds lw to $8; ID has add with rs=$8 -> id_stall=1 for one cycle, one bubble (ex_valid=0), then add loads. On the add's first EX cycle mwb_rd=8 with result 0xABCD, so alu_a=0xABCD.
- Stall/flush collision: stall_in=1 and flush=1 on the same edge -> stage becomes a bubble. stall_in=1 alone for 3 cycles -> all outputs hold, id_stall=1 each cycle.
- Shift operands: b_sel=2, shamt=31, a_sel=1, rt=0x1 -> alu_b=0x1F, alu_a=0x1.
- Macro off: ID rs=$3 while EX writes $3 via addi -> one bubble, no forwarded value.
